// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the TDC back-end: the windowing FSM state encoding
// and the default code width / window size. The TDC wrapper and the link
// adaptation logic use the same defaults.
// -----------------------------------------------------------------------------
package tdc_pkg;

   localparam int TDC_CODE_W = 8;
   localparam int TDC_LOG2N  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DUMP  = 2'd2
   } tdc_state_e;

endpackage

// File: rtl/tdc_code_diff.sv
// -----------------------------------------------------------------------------
// tdc_code_diff
// First-difference tracker: reports each accepted code minus the previously
// accepted one. No difference is reported for the first code after reset or
// after a clear.
//
// Ports
//   clk         system clock, posedge
//   rst         synchronous active-high reset
//   clear       forget the previous code (window abort)
//   code_in     unsigned code
//   code_valid  code is accepted this cycle
//   diff_out    signed code_in - prev, DIFF_W bits
//   diff_valid  one-cycle pulse when diff_out updates
// -----------------------------------------------------------------------------
module tdc_code_diff #(
   parameter int CODE_W = 8,
   parameter int DIFF_W = CODE_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic [CODE_W-1:0] code_in,
   input  logic              code_valid,
   output logic [DIFF_W-1:0] diff_out,
   output logic              diff_valid
);

   logic [CODE_W-1:0] prev_q;
   logic              have_prev_q;
   logic [DIFF_W-1:0] diff_q, diff_d;
   logic              diff_valid_q;

   // Zero-extend both operands one bit past CODE_W so the two's-complement
   // result covers the full -(2^CODE_W-1) .. +(2^CODE_W-1) range.
   assign diff_d = {{(DIFF_W-CODE_W){1'b0}}, code_in}
                 - {{(DIFF_W-CODE_W){1'b0}}, prev_q};

   always_ff @(posedge clk) begin
      diff_valid_q <= 1'b0;
      if (rst) begin
         prev_q      <= '0;
         have_prev_q <= 1'b0;
         diff_q      <= '0;
      end else if (clear) begin
         prev_q      <= '0;
         have_prev_q <= 1'b0;
      end else if (code_valid) begin
         if (have_prev_q) begin
            diff_q       <= diff_d;
            diff_valid_q <= 1'b1;
         end
         prev_q      <= code_in;
         have_prev_q <= 1'b1;
      end
   end

   assign diff_out   = diff_q;
   assign diff_valid = diff_valid_q;

endmodule

// File: rtl/tdc_code_avg.sv
// -----------------------------------------------------------------------------
// tdc_code_avg
// Windowed statistics over 2^LOG2N retimed TDC codes (floor average, min,
// max) plus a per-sample first difference.
//
// Ports
//   clk         system clock, posedge
//   rst         synchronous active-high reset
//   en          accumulation enable; dropping it mid-window aborts the window
//   code_in     unsigned TDC code
//   code_valid  single-cycle strobe qualifying code_in
//   avg_out     floor(sum/N) of the last completed window
//   min_out     minimum code of the last completed window
//   max_out     maximum code of the last completed window
//   avg_valid   one-cycle pulse when avg/min/max update
//   diff_out    signed code_in minus previous accepted code
//   diff_valid  one-cycle pulse when diff_out updates
// -----------------------------------------------------------------------------
module tdc_code_avg
   import tdc_pkg::*;
#(
   parameter int CODE_W = TDC_CODE_W,
   parameter int LOG2N  = TDC_LOG2N,
   parameter int DIFF_W = CODE_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [CODE_W-1:0] code_in,
   input  logic              code_valid,
   output logic [CODE_W-1:0] avg_out,
   output logic [CODE_W-1:0] min_out,
   output logic [CODE_W-1:0] max_out,
   output logic              avg_valid,
   output logic [DIFF_W-1:0] diff_out,
   output logic              diff_valid
);

   localparam int ACC_W = CODE_W + LOG2N;
   localparam logic [LOG2N-1:0] CNT_LAST = {LOG2N{1'b1}};

   tdc_state_e        state_q;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [LOG2N-1:0]  cnt_q;
   logic [CODE_W-1:0] win_min_q, win_max_q, min_d, max_d;
   logic [CODE_W-1:0] avg_q, min_out_q, max_out_q;
   logic              avg_valid_q;
   logic              accept, abort;

   // Samples are taken in ACCUM and also in DUMP, so a strobe landing on the
   // dump cycle starts the next window instead of being dropped.
   assign accept = code_valid && en && (state_q == ACCUM || state_q == DUMP);
   assign abort  = (state_q == ACCUM) && !en;

   // cnt_q == 0 marks the first sample of a window: load min/max directly.
   assign acc_d = acc_q + ACC_W'(code_in);
   assign min_d = (cnt_q == '0 || code_in < win_min_q) ? code_in : win_min_q;
   assign max_d = (cnt_q == '0 || code_in > win_max_q) ? code_in : win_max_q;

   always_ff @(posedge clk) begin
      avg_valid_q <= 1'b0;
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         win_min_q <= '0;
         win_max_q <= '0;
         avg_q     <= '0;
         min_out_q <= '0;
         max_out_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (en) state_q <= ACCUM;
            end
            ACCUM: begin
               if (!en) begin
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (code_valid) begin
                  acc_q     <= acc_d;
                  cnt_q     <= cnt_q + LOG2N'(1);   // wraps to 0 on the last one
                  win_min_q <= min_d;
                  win_max_q <= max_d;
                  if (cnt_q == CNT_LAST) state_q <= DUMP;
               end
            end
            DUMP: begin
               // acc_q holds the full window sum; the upper bits are floor(sum/N).
               avg_q       <= acc_q[ACC_W-1:LOG2N];
               min_out_q   <= win_min_q;
               max_out_q   <= win_max_q;
               avg_valid_q <= 1'b1;
               if (accept) begin
                  acc_q     <= ACC_W'(code_in);
                  cnt_q     <= LOG2N'(1);
                  win_min_q <= code_in;
                  win_max_q <= code_in;
               end else begin
                  acc_q <= '0;
                  cnt_q <= '0;
               end
               state_q <= en ? ACCUM : IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign avg_out   = avg_q;
   assign min_out   = min_out_q;
   assign max_out   = max_out_q;
   assign avg_valid = avg_valid_q;

   tdc_code_diff #(
      .CODE_W (CODE_W),
      .DIFF_W (DIFF_W)
   ) u_diff (
      .clk        (clk),
      .rst        (rst),
      .clear      (abort),
      .code_in    (code_in),
      .code_valid (accept),
      .diff_out   (diff_out),
      .diff_valid (diff_valid)
   );

endmodule
